axi_mem_arbiter: RTL and testbench

- Sits directly downstream of the core's fetch and load/store logic, and drives the core's single AXI4 master port (io_master_*).
- Accepts single-beat requests from two upstream clients: port 0 is IFU (read-only) and port 1 is LSU (read/write).
- Arbitrates between the clients round-robin and issues one AXI transaction at a time.
- Performs byte-lane alignment on write and read data, and returns a one-cycle response pulse to the client that was granted.

---
 rtl/axi_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: round-robin IFU/LSU arbiter issuing one single-beat AXI4 transaction at a time
module axi_mem_arbiter #(
    parameter logic [3:0] IFU_ID = 4'd0,
    parameter logic [3:0] LSU_ID = 4'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wmask,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        ls_rsp_err,
    output logic        io_master_awvalid,
    input  logic        io_master_awready,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,
    output logic        io_master_wvalid,
    input  logic        io_master_wready,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,
    output logic        io_master_bready,
    input  logic        io_master_bvalid,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid,
    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [31:0] io_master_rdata,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid
);
    typedef enum logic [2:0] {IDLE, CHK, AR, R, AWW, B, RSP} state_t;
    state_t state, state_d;
    logic last_ls, gnt_ls, sel_ls, we_q, aw_pend, w_pend, err_q, mis, aw_done, w_done, unused;
    logic [31:0] addr_q, wdata_q, data_q;
    logic [1:0] size_q;
    logic [3:0] wmask_q;
    logic [4:0] sh;
    // LSU wins a tie unless it was the last port served
    assign sel_ls = ls_req_valid && (!if_req_valid || !last_ls);
    assign mis = (size_q == 2'd1 && addr_q[0]) || (size_q == 2'd2 && addr_q[1:0] != 2'd0);
    assign aw_done = !aw_pend || io_master_awready;
    assign w_done = !w_pend || io_master_wready;
    assign sh = {addr_q[1:0], 3'b000};
    assign unused = ^{io_master_rid, io_master_rlast, io_master_bid, io_master_rresp[0], io_master_bresp[0]};
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = (if_req_valid || ls_req_valid) ? CHK : IDLE;
            CHK:     state_d = mis ? RSP : (we_q ? AWW : AR);
            AR:      state_d = io_master_arready ? R : AR;
            R:       state_d = io_master_rvalid ? RSP : R;
            AWW:     state_d = (aw_done && w_done) ? B : AWW;
            B:       state_d = io_master_bvalid ? RSP : B;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_d;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_ls <= 1'b0;
            gnt_ls  <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && (if_req_valid || ls_req_valid)) begin
                last_ls <= sel_ls;
                gnt_ls  <= sel_ls;
                addr_q  <= sel_ls ? ls_addr : if_addr;
                size_q  <= sel_ls ? ls_size : 2'd2;
                we_q    <= sel_ls && ls_we;
                wdata_q <= sel_ls ? ls_wdata : '0;
                wmask_q <= sel_ls ? ls_wmask : '0;
            end
            if (state == CHK) begin
                aw_pend <= we_q && !mis;
                w_pend  <= we_q && !mis;
                data_q  <= '0;
                err_q   <= mis;
            end
            if (state == AWW && io_master_awready) aw_pend <= 1'b0;
            if (state == AWW && io_master_wready) w_pend <= 1'b0;
            if (state == R && io_master_rvalid) begin
                data_q <= io_master_rdata >> sh;
                err_q  <= io_master_rresp[1];
            end
            if (state == B && io_master_bvalid) begin
                data_q <= '0;
                err_q  <= io_master_bresp[1];
            end
        end
    end
    assign if_req_ready = reset && state == IDLE && if_req_valid && !sel_ls;
    assign ls_req_ready = reset && state == IDLE && sel_ls;
    assign if_rsp_valid = state == RSP && !gnt_ls;
    assign ls_rsp_valid = state == RSP && gnt_ls;
    assign if_rsp_data = if_rsp_valid ? data_q : '0;
    assign ls_rsp_data = ls_rsp_valid ? data_q : '0;
    assign if_rsp_err = if_rsp_valid && err_q;
    assign ls_rsp_err = ls_rsp_valid && err_q;
    assign io_master_arvalid = state == AR;
    assign io_master_araddr = addr_q;
    assign io_master_arid = gnt_ls ? LSU_ID : IFU_ID;
    assign io_master_arlen = 8'd0;
    assign io_master_arsize = {1'b0, size_q};
    assign io_master_arburst = 2'b01;
    assign io_master_rready = state == R;
    assign io_master_awvalid = state == AWW && aw_pend;
    assign io_master_awaddr = addr_q;
    assign io_master_awid = LSU_ID;
    assign io_master_awlen = 8'd0;
    assign io_master_awsize = {1'b0, size_q};
    assign io_master_awburst = 2'b01;
    assign io_master_wvalid = state == AWW && w_pend;
    assign io_master_wdata = wdata_q << sh;
    assign io_master_wstrb = wmask_q << addr_q[1:0];
    assign io_master_wlast = 1'b1;
    assign io_master_bready = state == B;
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: scoreboard bench with a byte-level memory model and a randomised AXI slave
module tb_axi_mem_arbiter;
    logic clock = 1'b0, reset = 1'b0;
    logic if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_addr, if_rsp_data;
    logic ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid, ls_rsp_err;
    logic [31:0] ls_addr, ls_wdata, ls_rsp_data;
    logic [1:0] ls_size;
    logic [3:0] ls_wmask;
    logic awvalid, awready, wvalid, wready, wlast, bready, bvalid, arvalid, arready, rready, rvalid, rlast;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0] awid, wstrb, bid, arid, rid;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;

    axi_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_size(ls_size), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
        .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
        .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
        .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
        .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp), .io_master_bid(bid),
        .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
        .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
        .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
        .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0, cyc = 0, aw_cyc = 0, w_cyc = 0, aw_hold = 0, r_hold = 0;
    bit zw = 1'b1;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {logic [31:0] data; logic err; int acc; bit lat_chk; int lat;} rsp_t;
    typedef struct {logic [31:0] addr; logic [3:0] id; logic [2:0] size; logic we; logic [31:0] wdata; logic [3:0] wstrb;} axi_t;
    rsp_t if_q[$], ls_q[$];
    axi_t ax_q[$];
    int gl[$];
    logic [7:0] mem [logic [31:0]];
    logic [31:0] smem [logic [31:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_byte(a);
    endfunction
    function automatic logic [31:0] sword(input logic [31:0] w);
        return smem.exists(w) ? smem[w] : {init_byte(w + 3), init_byte(w + 2), init_byte(w + 1), init_byte(w)};
    endfunction
    task automatic preload(input logic [31:0] w, input logic [31:0] v);
        smem[w] = v;
        for (int i = 0; i < 4; i++) mem[w + 32'(i)] = v[8*i+:8];
    endtask

    // Reference: byte-addressed memory, expected results computed at the moment of acceptance
    task automatic accept(input bit ls, input bit we, input logic [31:0] a, input logic [1:0] size,
                          input logic [31:0] wd, input logic [3:0] wm);
        int off = int'(a[1:0]);
        logic [31:0] base = {a[31:2], 2'b00};
        bit mis = (size == 2'd1 && a[0]) || (size == 2'd2 && off != 0);
        bit berr = a[31:28] == 4'hE;
        rsp_t r;
        axi_t x;
        r.acc = cyc; r.lat_chk = zw && aw_hold == 0 && r_hold == 0; r.lat = mis ? 2 : 4;
        r.err = mis || berr; r.data = '0;
        if (!mis) begin
            x.addr = a; x.id = ls ? 4'd1 : 4'd0; x.size = {1'b0, size}; x.we = we; x.wdata = '0; x.wstrb = '0;
            for (int i = 0; i + off < 4; i++) begin
                if (we) begin
                    x.wdata[8*(i+off)+:8] = wd[8*i+:8];
                    if (wm[i]) begin
                        x.wstrb[i+off] = 1'b1;
                        if (!berr) mem[base + 32'(off + i)] = wd[8*i+:8];
                    end
                end else if (!berr) r.data[8*i+:8] = rd_byte(base + 32'(off + i));
            end
            ax_q.push_back(x);
        end
        if (ls) ls_q.push_back(r);
        else if_q.push_back(r);
    endtask

    task automatic req(input bit ls, input bit we, input logic [31:0] a, input logic [1:0] size,
                       input logic [31:0] wd, input logic [3:0] wm);
        int t = 0;
        @(posedge clock); #1;
        if (ls) begin
            ls_req_valid = 1; ls_we = we; ls_addr = a; ls_size = size; ls_wdata = wd; ls_wmask = wm;
        end else begin
            if_req_valid = 1; if_addr = a;
        end
        @(negedge clock);
        while (!(ls ? ls_req_ready : if_req_ready) && t < 300) begin @(negedge clock); t++; end
        if (!(ls ? ls_req_ready : if_req_ready)) begin
            check(ls ? "ls_accept_timeout" : "if_accept_timeout", 0, 1);
            if (ls) ls_req_valid = 0; else if_req_valid = 0;
            return;
        end
        accept(ls, ls && we, a, ls ? size : 2'd2, wd, wm);
        @(posedge clock); #1;
        if (ls) ls_req_valid = 0; else if_req_valid = 0;
        t = 0;
        @(negedge clock);
        while (!(ls ? ls_rsp_valid : if_rsp_valid) && t < 300) begin @(negedge clock); t++; end
        if (!(ls ? ls_rsp_valid : if_rsp_valid)) check(ls ? "ls_rsp_timeout" : "if_rsp_timeout", 0, 1);
    endtask

    function automatic logic any_out();
        return |{if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_data, ls_rsp_data, if_rsp_err,
                 ls_rsp_err, arvalid, awvalid, wvalid, bready, rready, araddr, awaddr, wdata, wstrb};
    endfunction

    task automatic pop_chk(input bit ls);
        rsp_t r;
        if ((ls ? ls_q.size() : if_q.size()) == 0) begin
            check(ls ? "ls_rsp_unexpected" : "if_rsp_unexpected", 1, 0);
            return;
        end
        r = ls ? ls_q.pop_front() : if_q.pop_front();
        check(ls ? "ls_rsp_data" : "if_rsp_data", ls ? ls_rsp_data : if_rsp_data, r.data);
        check(ls ? "ls_rsp_err" : "if_rsp_err", ls ? ls_rsp_err : if_rsp_err, r.err);
        if (r.lat_chk) check(ls ? "ls_latency" : "if_latency", cyc - r.acc, r.lat);
    endtask

    initial begin : monitor
        axi_t x;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (awvalid) aw_cyc++;
                if (wvalid) w_cyc++;
                if (if_req_ready) gl.push_back(0);
                if (ls_req_ready) gl.push_back(1);
                if (if_rsp_valid) pop_chk(0);
                if (ls_rsp_valid) pop_chk(1);
                if (arvalid && arready) begin
                    if (ax_q.size() == 0) check("ar_unexpected", 1, 0);
                    else begin
                        x = ax_q.pop_front();
                        check("ar_is_read", 0, x.we);
                        check("araddr", araddr, x.addr);
                        check("arid", arid, x.id);
                        check("arsize", arsize, x.size);
                        check("arlen_burst", {arlen, arburst}, {8'd0, 2'b01});
                    end
                end
                if (awvalid && awready) begin
                    if (ax_q.size() == 0) check("aw_unexpected", 1, 0);
                    else begin
                        check("aw_is_write", 1, ax_q[0].we);
                        check("awaddr", awaddr, ax_q[0].addr);
                        check("awid_size", {awid, awsize, awlen, awburst}, {ax_q[0].id, ax_q[0].size, 8'd0, 2'b01});
                    end
                end
                if (wvalid && wready) begin
                    if (ax_q.size() == 0) check("w_unexpected", 1, 0);
                    else begin
                        check("wdata", wdata, ax_q[0].wdata);
                        check("wstrb_last", {wstrb, wlast}, {ax_q[0].wstrb, 1'b1});
                    end
                end
                if (bvalid && bready && ax_q.size() != 0) void'(ax_q.pop_front());
            end
        end
    end

    initial begin : slave
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, got_aw, got_w;
        logic [31:0] ar_a, aw_a, w_d, r_a, b_a, wd_q, word;
        logic [3:0] w_s, ws_q;
        int r_cnt, b_cnt;
        {arready, awready, wready, rvalid, bvalid, r_pend, b_pend, got_aw, got_w} = '0;
        rdata = '0; rresp = '0; rlast = 1'b1; rid = '0; bresp = '0; bid = 4'd1;
        r_a = '0; b_a = '0; wd_q = '0; ws_q = '0; r_cnt = 0; b_cnt = 0;
        forever begin
            @(negedge clock);
            ar_hs = arvalid && arready; r_hs = rvalid && rready; aw_hs = awvalid && awready;
            w_hs = wvalid && wready; b_hs = bvalid && bready;
            ar_a = araddr; aw_a = awaddr; w_d = wdata; w_s = wstrb;
            @(posedge clock); #1;
            if (!reset) begin
                {arready, awready, wready, rvalid, bvalid, r_pend, b_pend, got_aw, got_w} = '0;
            end else begin
                if (r_hs) rvalid = 0;
                if (b_hs) bvalid = 0;
                if (ar_hs) begin r_pend = 1; r_a = ar_a; r_cnt = zw ? r_hold : int'($urandom_range(0, 3)); end
                if (aw_hs) begin got_aw = 1; b_a = aw_a; end
                if (w_hs) begin got_w = 1; wd_q = w_d; ws_q = w_s; end
                if (got_aw && got_w) begin
                    word = sword({b_a[31:2], 2'b00});
                    for (int i = 0; i < 4; i++) if (ws_q[i]) word[8*i+:8] = wd_q[8*i+:8];
                    if (b_a[31:28] != 4'hE) smem[{b_a[31:2], 2'b00}] = word;
                    got_aw = 0; got_w = 0; b_pend = 1; b_cnt = zw ? 0 : int'($urandom_range(0, 3));
                end
                if (r_pend) begin
                    if (r_cnt == 0) begin
                        rvalid = 1; r_pend = 0;
                        rresp = r_a[31:28] == 4'hE ? 2'b10 : 2'b00;
                        rdata = r_a[31:28] == 4'hE ? 32'd0 : sword({r_a[31:2], 2'b00});
                    end else r_cnt--;
                end
                if (b_pend) begin
                    if (b_cnt == 0) begin
                        bvalid = 1; b_pend = 0;
                        bresp = b_a[31:28] == 4'hE ? 2'b10 : 2'b00;
                    end else b_cnt--;
                end
                arready = zw ? 1'b1 : 1'($urandom_range(0, 1));
                wready = zw ? 1'b1 : 1'($urandom_range(0, 1));
                if (awvalid && aw_hold > 0) begin awready = 0; aw_hold--; end
                else awready = zw ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    end

    function automatic logic [31:0] rnd_base();
        return ($urandom_range(0, 9) == 0 ? 32'hE000_0000 : 32'h2000_0000) | 32'($urandom_range(0, 31));
    endfunction

    initial begin
        int t;
        logic [3:0] g;
        {if_req_valid, ls_req_valid, ls_we} = '0;
        if_addr = '0; ls_addr = '0; ls_size = '0; ls_wdata = '0; ls_wmask = '0;
        preload(32'h2000_0004, 32'hDEAD_BEEF);
        repeat (2) @(posedge clock); #1;
        if_req_valid = 1; ls_req_valid = 1;
        #1 check("reset_outputs_zero", any_out(), 0);
        if_req_valid = 0; ls_req_valid = 0;
        @(negedge clock); reset = 1;
        fork
            begin req(0, 0, 32'h2000_0000, 2, 0, 0); req(0, 0, 32'h2000_0004, 2, 0, 0); end
            begin req(1, 0, 32'h2000_0008, 2, 0, 0); req(1, 0, 32'h2000_000C, 2, 0, 0); end
        join
        check("grant_count", gl.size(), 4);
        if (gl.size() >= 4) begin
            g = {gl[0][0], gl[1][0], gl[2][0], gl[3][0]};
            check("grant_order", g, 4'b1010);
        end
        req(0, 0, 32'h2000_0004, 2, 0, 0);
        req(1, 1, 32'h0F00_0003, 0, 32'h0000_00A5, 4'b0001);
        req(1, 0, 32'h0F00_0000, 2, 0, 0);
        req(1, 0, 32'h8000_0001, 1, 0, 0);
        aw_hold = 3; aw_cyc = 0; w_cyc = 0;
        req(1, 1, 32'h2000_0010, 2, 32'h1234_5678, 4'hF);
        check("awvalid_cycles", aw_cyc, 4);
        check("wvalid_cycles", w_cyc, 1);
        aw_hold = 0;
        req(1, 0, 32'h2000_0010, 2, 0, 0);
        req(1, 0, 32'hE000_0000, 2, 0, 0);
        req(0, 0, 32'hE000_0004, 2, 0, 0);
        r_hold = 5;
        @(posedge clock); #1; if_req_valid = 1; if_addr = 32'h2000_0008;
        t = 0;
        @(negedge clock);
        while (!if_req_ready && t < 50) begin @(negedge clock); t++; end
        check("rst_test_accept", if_req_ready, 1);
        accept(0, 0, 32'h2000_0008, 2, 0, 0);
        @(posedge clock); #1; if_req_valid = 0;
        t = 0;
        @(negedge clock);
        while (!rready && t < 50) begin @(negedge clock); t++; end
        check("rst_test_in_r", rready, 1);
        reset = 0;
        #1 check("reset_mid_r_outputs_zero", any_out(), 0);
        if_q.delete(); ax_q.delete(); r_hold = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        req(0, 0, 32'h2000_000C, 2, 0, 0);
        zw = 0;
        fork
            for (int i = 0; i < 120; i++) begin
                logic [31:0] a = rnd_base() & 32'hFFFF_FFFC;
                if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
                req(0, 0, a, 2, 0, 0);
            end
            for (int i = 0; i < 120; i++) begin
                logic [1:0] sz = 2'($urandom_range(0, 2));
                logic [31:0] a = rnd_base();
                if ($urandom_range(0, 5) != 0) a = sz == 2 ? a & 32'hFFFF_FFFC : (sz == 1 ? a & 32'hFFFF_FFFE : a);
                req(1, 1'($urandom_range(0, 1)), a, sz, $urandom, sz == 2 ? 4'hF : (sz == 1 ? 4'h3 : 4'h1));
            end
        join
        repeat (3) @(negedge clock);
        check("if_queue_drained", if_q.size(), 0);
        check("ls_queue_drained", ls_q.size(), 0);
        check("axi_queue_drained", ax_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
